// File: rtl/dataram_pkg.sv
// Shared encodings for the data RAM access controller: request opcodes, FSM states
// and the base of the bit-addressable byte region.
package dataram_pkg;

  typedef enum logic [2:0] {
    OP_RD_BYTE  = 3'b000,
    OP_WR_BYTE  = 3'b001,
    OP_INC_BYTE = 3'b010,
    OP_DEC_BYTE = 3'b011,
    OP_RD_BIT   = 3'b100,
    OP_WR_BIT   = 3'b101,
    OP_CPL_BIT  = 3'b110,
    OP_RSVD     = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MOD  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [7:0] BIT_BASE   = 8'h20;
  localparam int         RD_LAT_MAX = 3;

  // Bit-space opcodes all carry op[2]; the reserved code is screened out separately.
  function automatic logic is_bit_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/dataram_access_ctrl_bit_addr_decode.sv
// Maps a 7-bit 8051 bit address onto its byte in the 0x20-0x2F region and a one-hot lane.
module bit_addr_decode
  import dataram_pkg::*;
(
  input  logic [6:0] bit_addr,
  output logic [7:0] addr,
  output logic [7:0] position
);

  assign addr     = BIT_BASE + {4'b0000, bit_addr[6:3]};
  assign position = 8'h01 << bit_addr[2:0];

endmodule

// File: rtl/dataram_access_ctrl.sv
// Single-outstanding-request initiator for the byte/bit data RAM port, including
// read-modify-write sequencing for INC/DEC byte and CPL bit.
module dataram_access_ctrl
  import dataram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [2:0] op,
  input  logic [7:0] baddr,
  input  logic [7:0] wdata,
  input  logic       wbit,
  output logic       busy,
  output logic       ack,
  output logic       err,
  output logic [7:0] rdata,
  output logic       rbit,
  output logic       CS,
  output logic       RW,
  output logic       Bb,
  output logic [7:0] addr,
  output logic [7:0] position,
  output logic [7:0] din,
  output logic       bin,
  input  logic [7:0] dout,
  input  logic       bout
);

  state_e      state;
  op_e         op_q;
  logic [1:0]  cnt;
  logic [7:0]  rd_byte;
  logic        rd_bit;
  logic [7:0]  dec_addr;
  logic [7:0]  dec_pos;

  bit_addr_decode u_dec (
    .bit_addr (baddr[6:0]),
    .addr     (dec_addr),
    .position (dec_pos)
  );

  function automatic logic [7:0] rmw_byte(input op_e o, input logic [7:0] v);
    return (o == OP_INC_BYTE) ? v + 8'd1 : v - 8'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_RD_BYTE;
      cnt      <= '0;
      rd_byte  <= '0;
      rd_bit   <= 1'b0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      rbit     <= 1'b0;
      CS       <= 1'b1;
      RW       <= 1'b1;
      Bb       <= 1'b1;
      addr     <= '0;
      position <= '0;
      din      <= '0;
      bin      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q <= op_e'(op);
            busy <= 1'b1;
            if (op == OP_RSVD || (is_bit_op(op) && baddr[7])) begin
              state <= ST_DONE;
              ack   <= 1'b1;
              err   <= 1'b1;
            end else begin
              Bb       <= ~is_bit_op(op);
              addr     <= is_bit_op(op) ? dec_addr : baddr;
              position <= is_bit_op(op) ? dec_pos : 8'h00;
              CS       <= 1'b0;
              if (op == OP_WR_BYTE || op == OP_WR_BIT) begin
                state <= ST_WR;
                RW    <= 1'b0;
                din   <= (op == OP_WR_BYTE) ? wdata : 8'h00;
                bin   <= (op == OP_WR_BIT) ? wbit : 1'b0;
              end else begin
                state <= ST_RD;
                RW    <= 1'b1;
                cnt   <= 2'(RD_LAT - 1);
              end
            end
          end
        end
        ST_RD: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            CS      <= 1'b1;
            rd_byte <= dout;
            rd_bit  <= bout;
            if (op_q == OP_RD_BYTE) begin
              rdata <= dout;
              state <= ST_DONE;
              ack   <= 1'b1;
            end else if (op_q == OP_RD_BIT) begin
              rbit  <= bout;
              state <= ST_DONE;
              ack   <= 1'b1;
            end else begin
              state <= ST_MOD;
            end
          end
        end
        ST_MOD: begin
          din   <= is_bit_op(op_q) ? 8'h00 : rmw_byte(op_q, rd_byte);
          bin   <= is_bit_op(op_q) ? ~rd_bit : 1'b0;
          CS    <= 1'b0;
          RW    <= 1'b0;
          state <= ST_WR;
        end
        ST_WR: begin
          CS    <= 1'b1;
          RW    <= 1'b1;
          state <= ST_DONE;
          ack   <= 1'b1;
          if (op_q == OP_INC_BYTE || op_q == OP_DEC_BYTE) rdata <= din;
          if (op_q == OP_CPL_BIT) rbit <= bin;
        end
        ST_DONE: begin
          // Return every RAM-side output to its idle value before accepting again.
          state    <= ST_IDLE;
          busy     <= 1'b0;
          ack      <= 1'b0;
          err      <= 1'b0;
          Bb       <= 1'b1;
          addr     <= '0;
          position <= '0;
          din      <= '0;
          bin      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dataram_access_ctrl.sv
// Scoreboard bench for dataram_access_ctrl against a behavioural byte/bit RAM.
module tb_dataram_access_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] baddr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       wbit = 1'b0;
  logic       busy, ack, err, rbit, CS, RW, Bb, bin, bout;
  logic [7:0] rdata, addr, position, din, dout;
  logic       ram_clr = 1'b1;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;
  int accepts = 0;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    logic       rbit;
    int         lat;
    int         cs_lo;
    int         wr_lo;
    logic [7:0] addr;
    logic [7:0] pos;
    logic       bb;
    logic [7:0] din;
    logic       bin;
  } exp_t;

  exp_t sb[$];

  dataram_access_ctrl #(.RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .baddr(baddr), .wdata(wdata),
    .wbit(wbit), .busy(busy), .ack(ack), .err(err), .rdata(rdata), .rbit(rbit),
    .CS(CS), .RW(RW), .Bb(Bb), .addr(addr), .position(position), .din(din),
    .bin(bin), .dout(dout), .bout(bout)
  );

  always #5 clk = ~clk;

  assign dout = mem[addr];
  assign bout = |(mem[addr] & position);

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (!CS && !RW) begin
      if (Bb) mem[addr] <= din;
      else    mem[addr] <= (mem[addr] & ~position) | (bin ? position : 8'h00);
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic e, input logic [7:0] rd, input logic rb,
                              input int lat, input int cs, input int wr,
                              input logic [7:0] a, input logic [7:0] p, input logic bb,
                              input logic [7:0] d, input logic b);
    exp_t x;
    x.err = e; x.rdata = rd; x.rbit = rb; x.lat = lat; x.cs_lo = cs; x.wr_lo = wr;
    x.addr = a; x.pos = p; x.bb = bb; x.din = d; x.bin = b;
    return x;
  endfunction

  // Monitor: tracks each accepted request on the negative edge and scores it at ack.
  bit         active = 0;
  int         cyc, cs_lo, wr_lo;
  logic [7:0] m_addr, m_pos, m_din;
  logic       m_bb, m_bin, unstable;

  always @(negedge clk) begin
    if (reset) begin
      active = 0;
    end else begin
      if (active) begin
        cyc++;
        if (!CS) begin
          if (cs_lo == 0) begin
            m_addr = addr; m_pos = position; m_bb = Bb;
          end else if (addr !== m_addr || position !== m_pos || Bb !== m_bb) begin
            unstable = 1;
          end
          cs_lo++;
          if (!RW) begin
            wr_lo++; m_din = din; m_bin = bin;
          end
        end
      end
      if (ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("err", err, e.err);
          chk("rdata", rdata, e.rdata);
          chk("rbit", rbit, e.rbit);
          chk("latency", cyc, e.lat);
          chk("cs_low_cycles", cs_lo, e.cs_lo);
          chk("write_cycles", wr_lo, e.wr_lo);
          if (e.cs_lo > 0) begin
            chk("addr", m_addr, e.addr);
            chk("position", m_pos, e.pos);
            chk("Bb", m_bb, e.bb);
            chk("addr_stable", unstable, 0);
          end
          if (e.wr_lo > 0) begin
            chk("din", m_din, e.din);
            chk("bin", m_bin, e.bin);
          end
        end
        active = 0;
      end
      if (req && !busy) begin
        active = 1; cyc = 0; cs_lo = 0; wr_lo = 0; unstable = 0;
        accepts++;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] wd,
                       input logic wb, input exp_t e);
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; op = o; baddr = a; wdata = wd; wbit = wb;
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    repeat (3) @(posedge clk);
    #1 ram_clr = 1'b0;
    @(negedge clk);
    chk("rst_CS", CS, 1);           chk("rst_RW", RW, 1);
    chk("rst_Bb", Bb, 1);           chk("rst_addr", addr, 0);
    chk("rst_position", position, 0); chk("rst_din", din, 0);
    chk("rst_bin", bin, 0);         chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);         chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);     chk("rst_rbit", rbit, 0);
    reset = 1'b0;

    issue(3'b001, 8'h45, 8'hA5, 1'b0, mk(0, 8'h00, 0, 2, 1, 1, 8'h45, 8'h00, 1, 8'hA5, 0));
    issue(3'b000, 8'h45, 8'h00, 1'b0, mk(0, 8'hA5, 0, 2, 1, 0, 8'h45, 8'h00, 1, 8'h00, 0));
    issue(3'b101, 8'h13, 8'h00, 1'b1, mk(0, 8'hA5, 0, 2, 1, 1, 8'h22, 8'h08, 0, 8'h00, 1));
    issue(3'b100, 8'h13, 8'h00, 1'b0, mk(0, 8'hA5, 1, 2, 1, 0, 8'h22, 8'h08, 0, 8'h00, 0));
    issue(3'b000, 8'h22, 8'h00, 1'b0, mk(0, 8'h08, 1, 2, 1, 0, 8'h22, 8'h00, 1, 8'h00, 0));
    issue(3'b001, 8'h30, 8'hFF, 1'b0, mk(0, 8'h08, 1, 2, 1, 1, 8'h30, 8'h00, 1, 8'hFF, 0));
    issue(3'b010, 8'h30, 8'h00, 1'b0, mk(0, 8'h00, 1, 4, 2, 1, 8'h30, 8'h00, 1, 8'h00, 0));
    chk("mem30_after_inc", mem[8'h30], 8'h00);
    issue(3'b000, 8'h30, 8'h00, 1'b0, mk(0, 8'h00, 1, 2, 1, 0, 8'h30, 8'h00, 1, 8'h00, 0));
    issue(3'b011, 8'h30, 8'h00, 1'b0, mk(0, 8'hFF, 1, 4, 2, 1, 8'h30, 8'h00, 1, 8'hFF, 0));
    issue(3'b001, 8'h2F, 8'h7F, 1'b0, mk(0, 8'hFF, 1, 2, 1, 1, 8'h2F, 8'h00, 1, 8'h7F, 0));
    issue(3'b110, 8'h7F, 8'h00, 1'b0, mk(0, 8'hFF, 1, 4, 2, 1, 8'h2F, 8'h80, 0, 8'h00, 1));
    issue(3'b110, 8'h7F, 8'h00, 1'b0, mk(0, 8'hFF, 0, 4, 2, 1, 8'h2F, 8'h80, 0, 8'h00, 0));
    issue(3'b000, 8'h2F, 8'h00, 1'b0, mk(0, 8'h7F, 0, 2, 1, 0, 8'h2F, 8'h00, 1, 8'h00, 0));
    issue(3'b100, 8'h80, 8'h00, 1'b0, mk(1, 8'h7F, 0, 1, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0));
    issue(3'b111, 8'h10, 8'h00, 1'b0, mk(1, 8'h7F, 0, 1, 0, 0, 8'h00, 8'h00, 1, 8'h00, 0));

    // Abort an INC during its write cycle; the RAM byte must survive.
    issue(3'b001, 8'h50, 8'h33, 1'b0, mk(0, 8'h7F, 0, 2, 1, 1, 8'h50, 8'h00, 1, 8'h33, 0));
    @(posedge clk); #1;
    req = 1'b1; op = 3'b010; baddr = 8'h50;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(CS == 1'b0 && RW == 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wr_state", (CS == 1'b0 && RW == 1'b0), 1);
    reset = 1'b1;
    #1;
    chk("abort_CS", CS, 1);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_mem50", mem[8'h50], 8'h33);
    chk("abort_rdata", rdata, 8'h00);

    // Hold req high across three requests.
    acc0 = accepts;
    for (int i = 0; i < 3; i++)
      sb.push_back(mk(0, 8'hA5, 0, 2, 1, 0, 8'h45, 8'h00, 1, 8'h00, 0));
    @(posedge clk); #1;
    req = 1'b1; op = 3'b000; baddr = 8'h45;
    n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      if (!busy) n++;
    end
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("held_req_accepts", accepts - acc0, 3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
